// File: rtl/fpu_f2i_pipe.sv
// fpu_f2i_pipe: three-stage pipelined float-to-integer converter.
// Stage 1 decodes the operand, stage 2 aligns the significand into an
// integer plus guard/round/sticky bits, and stage 3 rounds, negates and
// saturates. The output registers form stage 3. Every stage has a
// valid bit and carries its own tag, so results leave in issue order.
// A bubble in any stage is filled even while the output is stalled.
module fpu_f2i_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int INT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_float,
  input  logic [2:0]               in_rm,
  input  logic                     in_unsigned,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INT_W-1:0]         out_int,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_nv,
  output logic                     out_nx
);

  // Exponent bias of the float format; fixed by the exponent width.
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int SIG_W  = MAN_W + 1;
  // Largest useful right shift: beyond this the whole significand is
  // already below the round bit, so only sticky is affected.
  localparam int RS_MAX = INT_W + MAN_W + 2;
  localparam int RS_W   = $clog2(RS_MAX + 1);
  // Sticky field below G/R, wide enough that the clamped shift never
  // pushes significand bits off the bottom of the alignment vector.
  localparam int SW     = 2 * MAN_W + 2;
  // Alignment vector: INT_W integer bits, G, R, then the sticky field.
  localparam int VW     = INT_W + 2 + SW;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // ------------------------------------------------------------------
  // Pipeline load enables (bubbles collapse toward the output)
  // ------------------------------------------------------------------
  logic w_ld1;
  logic w_ld2;
  logic w_ld3;

  // ------------------------------------------------------------------
  // Stage 1 registers
  // ------------------------------------------------------------------
  logic             r1_valid;
  logic             r1_sign;
  logic             r1_nan;
  logic             r1_inf;
  logic             r1_sub;
  logic             r1_big;
  logic [SIG_W-1:0] r1_sig;
  logic [RS_W-1:0]  r1_rs;
  logic [2:0]       r1_rm;
  logic             r1_uns;
  logic [TAG_W-1:0] r1_tag;

  // ------------------------------------------------------------------
  // Stage 2 registers
  // ------------------------------------------------------------------
  logic             r2_valid;
  logic             r2_sign;
  logic             r2_nan;
  logic             r2_inf;
  logic             r2_big;
  logic [INT_W-1:0] r2_int;
  logic             r2_g;
  logic             r2_r;
  logic             r2_s;
  logic [2:0]       r2_rm;
  logic             r2_uns;
  logic [TAG_W-1:0] r2_tag;

  // ------------------------------------------------------------------
  // Stage 1 decode wires
  // ------------------------------------------------------------------
  logic               w1_sign;
  logic [EXP_W-1:0]   w1_exp;
  logic [MAN_W-1:0]   w1_man;
  logic               w1_exp_zero;
  logic               w1_exp_max;
  logic               w1_man_zero;
  logic               w1_nan;
  logic               w1_inf;
  logic               w1_sub;
  logic [SIG_W-1:0]   w1_sig;
  logic signed [31:0] w1_e;
  logic signed [31:0] w1_rs_raw;
  logic               w1_big;
  logic [RS_W-1:0]    w1_rs;

  // ------------------------------------------------------------------
  // Stage 2 alignment wires
  // ------------------------------------------------------------------
  logic [VW-1:0]    w2_vec;
  logic [VW-1:0]    w2_shifted;
  logic [INT_W-1:0] w2_int;
  logic             w2_g;
  logic             w2_r;
  logic             w2_s;

  // ------------------------------------------------------------------
  // Stage 3 rounding wires
  // ------------------------------------------------------------------
  logic             w3_inexact;
  logic             w3_inc;
  logic [INT_W:0]   w3_mag;
  logic [INT_W-1:0] w3_neg;
  logic             w3_ovf_sp;
  logic             w3_ovf_sn;
  logic             w3_ovf_up;
  logic             w3_ovf_un;
  logic             w3_ovf;
  logic [INT_W-1:0] w3_max;
  logic [INT_W-1:0] w3_min;
  logic [INT_W-1:0] w3_res;
  logic             w3_nv;
  logic             w3_nx;

  // Handshake: the output stage frees when consumed, earlier stages
  // free when empty or when the stage after them loads.
  assign w_ld3    = ~out_valid | out_ready;
  assign w_ld2    = ~r2_valid | w_ld3;
  assign w_ld1    = ~r1_valid | w_ld2;
  assign in_ready = w_ld1;

  // ------------------------------------------------------------------
  // Stage 1: classify the operand and derive the alignment shift
  // ------------------------------------------------------------------
  assign w1_sign     = in_float[EXP_W+MAN_W];
  assign w1_exp      = in_float[EXP_W+MAN_W-1:MAN_W];
  assign w1_man      = in_float[MAN_W-1:0];
  assign w1_exp_zero = ~|w1_exp;
  assign w1_exp_max  = &w1_exp;
  assign w1_man_zero = ~|w1_man;
  assign w1_nan      = w1_exp_max & ~w1_man_zero;
  assign w1_inf      = w1_exp_max & w1_man_zero;
  assign w1_sub      = w1_exp_zero & ~w1_man_zero;
  // Zero and subnormals have no hidden bit; a zero significand yields
  // an exact integer 0 without any special casing.
  assign w1_sig      = {~w1_exp_zero, w1_man};

  // Unbiased exponent; the significand MSB sits at integer bit e.
  assign w1_e      = $signed({{(32-EXP_W){1'b0}}, w1_exp}) - BIAS;
  // The significand is pre-placed with its MSB at integer bit INT_W-1,
  // so a right shift of INT_W-1-e puts it at its true weight.
  assign w1_rs_raw = INT_W - 1 - w1_e;
  // Magnitude of at least 2^INT_W cannot fit any target.
  assign w1_big    = (w1_e >= INT_W);

  // Clamp the shift so tiny values still land in the sticky field.
  always_comb begin
    w1_rs = '0;
    if (w1_big) begin
      w1_rs = '0;
    end else if (w1_rs_raw > RS_MAX) begin
      w1_rs = RS_W'(RS_MAX);
    end else begin
      w1_rs = w1_rs_raw[RS_W-1:0];
    end
  end

  // Stage 1 register: capture the decoded operand when stage 1 loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_nan   <= 1'b0;
      r1_inf   <= 1'b0;
      r1_sub   <= 1'b0;
      r1_big   <= 1'b0;
      r1_sig   <= '0;
      r1_rs    <= '0;
      r1_rm    <= '0;
      r1_uns   <= 1'b0;
      r1_tag   <= '0;
    end else if (w_ld1) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign <= w1_sign;
        r1_nan  <= w1_nan;
        r1_inf  <= w1_inf;
        r1_sub  <= w1_sub;
        r1_big  <= w1_big;
        r1_sig  <= w1_sig;
        r1_rs   <= w1_rs;
        r1_rm   <= in_rm;
        r1_uns  <= in_unsigned;
        r1_tag  <= in_tag;
      end
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: align the significand into integer, G, R and sticky
  // ------------------------------------------------------------------
  assign w2_vec     = {r1_sig, {(VW-SIG_W){1'b0}}};
  assign w2_shifted = w2_vec >> r1_rs;

  // Split the aligned vector; subnormals are always below one half.
  always_comb begin
    w2_int = w2_shifted[VW-1 -: INT_W];
    w2_g   = w2_shifted[SW+1];
    w2_r   = w2_shifted[SW];
    w2_s   = |w2_shifted[SW-1:0];
    if (r1_sub) begin
      w2_int = '0;
      w2_g   = 1'b0;
      w2_r   = 1'b0;
      w2_s   = 1'b1;
    end
  end

  // Stage 2 register: hold the aligned magnitude when stage 2 loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_nan   <= 1'b0;
      r2_inf   <= 1'b0;
      r2_big   <= 1'b0;
      r2_int   <= '0;
      r2_g     <= 1'b0;
      r2_r     <= 1'b0;
      r2_s     <= 1'b0;
      r2_rm    <= '0;
      r2_uns   <= 1'b0;
      r2_tag   <= '0;
    end else if (w_ld2) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sign <= r1_sign;
        r2_nan  <= r1_nan;
        r2_inf  <= r1_inf;
        r2_big  <= r1_big;
        r2_int  <= w2_int;
        r2_g    <= w2_g;
        r2_r    <= w2_r;
        r2_s    <= w2_s;
        r2_rm   <= r1_rm;
        r2_uns  <= r1_uns;
        r2_tag  <= r1_tag;
      end
    end
  end

  // ------------------------------------------------------------------
  // Stage 3: round, negate, detect overflow, pick the result
  // ------------------------------------------------------------------
  assign w3_inexact = r2_g | r2_r | r2_s;

  // Rounding increment decision for each rounding mode.
  always_comb begin
    w3_inc = 1'b0;
    case (r2_rm)
      RM_RNE:  w3_inc = r2_g & (r2_r | r2_s | r2_int[0]);
      RM_RTZ:  w3_inc = 1'b0;
      RM_RDN:  w3_inc = r2_sign & w3_inexact;
      RM_RUP:  w3_inc = ~r2_sign & w3_inexact;
      RM_RMM:  w3_inc = r2_g;
      default: w3_inc = 1'b0;
    endcase
  end

  // One extra bit so a carry out of the rounding add is not lost.
  assign w3_mag = {1'b0, r2_int} + {{INT_W{1'b0}}, w3_inc};
  assign w3_neg = {INT_W{1'b0}} - w3_mag[INT_W-1:0];

  // Range limits on the rounded magnitude for each target and sign.
  assign w3_ovf_sp = w3_mag[INT_W] | w3_mag[INT_W-1];
  assign w3_ovf_sn = w3_mag[INT_W] | (w3_mag[INT_W-1] & (|w3_mag[INT_W-2:0]));
  assign w3_ovf_up = w3_mag[INT_W];
  assign w3_ovf_un = |w3_mag;
  assign w3_ovf    = r2_big |
                     (r2_uns ? (r2_sign ? w3_ovf_un : w3_ovf_up)
                             : (r2_sign ? w3_ovf_sn : w3_ovf_sp));

  // Saturation values for the selected target type.
  assign w3_max = r2_uns ? {INT_W{1'b1}} : {1'b0, {(INT_W-1){1'b1}}};
  assign w3_min = r2_uns ? {INT_W{1'b0}} : {1'b1, {(INT_W-1){1'b0}}};

  // Result selection; exceptions never report inexact.
  always_comb begin
    w3_res = '0;
    w3_nv  = 1'b0;
    w3_nx  = 1'b0;
    if (r2_rm > RM_RMM) begin
      w3_res = '0;
      w3_nv  = 1'b1;
    end else if (r2_nan) begin
      w3_res = w3_max;
      w3_nv  = 1'b1;
    end else if (r2_inf | w3_ovf) begin
      w3_res = r2_sign ? w3_min : w3_max;
      w3_nv  = 1'b1;
    end else begin
      w3_res = r2_sign ? w3_neg : w3_mag[INT_W-1:0];
      w3_nx  = w3_inexact;
    end
  end

  // Output register: loads when empty or consumed, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_int   <= '0;
      out_tag   <= '0;
      out_nv    <= 1'b0;
      out_nx    <= 1'b0;
    end else if (w_ld3) begin
      out_valid <= r2_valid;
      if (r2_valid) begin
        out_int <= w3_res;
        out_tag <= r2_tag;
        out_nv  <= w3_nv;
        out_nx  <= w3_nx;
      end
    end
  end

endmodule

// File: doc/fpu_f2i_pipe.md
Name: fpu_f2i_pipe

Overview:
- Pipelined, parametrised float-to-integer converter for the FPU: any EXP_W/MAN_W float format (Bfloat16 default, IEEE16/32 by parameter) to a signed or unsigned INT_W-bit integer.
- Three register stages with valid/ready handshake and a pass-through tag, so the FPU issue logic can stream one conversion per cycle and tolerate writeback backpressure.
- Implements RISC-V FCVT.W/WU/L/LU semantics, including correct inexact-only handling of negative values that round to zero for unsigned targets.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 7, stored mantissa width (hidden bit excluded).
- INT_W, 32, integer result width (32 or 64).
- TAG_W, 4, width of the opaque tag carried alongside each operation.
- BIAS derived localparam, 2^(EXP_W-1)-1, not overridable.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  stage 1 can accept this cycle.
- in_float  in  EXP_W+MAN_W+1  operand {sign, exp, man}.
- in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, 101-111 reserved.
- in_unsigned  in  1  1 = unsigned target, 0 = signed.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_int  out  INT_W  converted integer.
- out_tag  out  TAG_W  tag of this result.
- out_nv  out  1  invalid flag.
- out_nx  out  1  inexact flag.

Behaviour:
- Reset: all stage valid bits 0; out_valid=0, out_int=0, out_tag=0, out_nv=0, out_nx=0. in_ready=1 after reset. Reset mid-flight discards every in-flight operation; nothing is emitted.
- Handshake: transfer occurs when valid&ready are both high. Stage k loads when its valid is 0 or stage k+1 loads this cycle (bubbles collapse). Stage 3 loads when out_valid=0 or out_ready=1. in_ready is stage 1's load enable.
- out_* hold stable while out_valid=1 and out_ready=0.
- Latency is 3 cycles from accept to out_valid with no stall; throughput is 1 per cycle.
- S1 decode:
  - classify zero, subnormal, normal, inf, NaN;
  - compute unbiased exponent e = exp - BIAS;
  - compute significand {hidden, man};
  - compute the right-shift amount, clamped to INT_W+MAN_W+2.
- S2 shift:
  - align the significand into an INT_W integer part plus guard (G), round (R) and sticky (S);
  - S is the OR of all bits shifted past R;
  - subnormals yield integer 0 with S=1.
- S3 round:
  - increment when one of these holds:
    - RNE: G&(R|S|lsb);
    - RMM: G;
    - RUP: ~sign&(G|R|S);
    - RDN: sign&(G|R|S);
    - RTZ: never.
  - The magnitude adder is INT_W+1 bits so the carry-out is kept.
  - Negate (two's complement) when sign=1.
  - Overflow is checked on the rounded magnitude M:
    - signed, positive: M > 2^(INT_W-1)-1;
    - signed, negative: M > 2^(INT_W-1);
    - unsigned, positive: M > 2^INT_W-1;
    - unsigned, negative: M != 0.
- Exception results, each with nv=1 and nx=0:
  - NaN: signed max (2^(INT_W-1)-1) or unsigned max (all ones).
  - +inf and positive overflow: the same max value.
  - -inf and negative overflow: signed min (1 followed by zeros) or unsigned 0.
- Reserved rm (101-111): out_int=0, nv=1, nx=0.
- Non-exception results: nv=0 and nx=G|R|S. Rounding never sets nx alone.
- Specific cases:
  - Negative value whose rounded magnitude is 0 on an unsigned target: out_int=0, nv=0, nx=1.
  - -0.0 and +0.0: out_int=0, no flags.
  - Exact -2^(INT_W-1) on a signed target: min value, no flags.
- Tag and flags travel with their operation through every stage. No reordering.

Test Plan:
- Default params, signed, stream 0x3FC0 (1.5) RNE, then 0x4020 (2.5) RNE, then 0x4020 RMM, with out_ready=1 throughout. Required: outputs 2, 2, 3, each with nx=1, on consecutive cycles at cycles 3, 4, 5 after the first accept, tags preserved.
- Signed 0xC020 (-2.5) with RDN -> 0xFFFFFFFD, nx=1. The same input with RUP -> 0xFFFFFFFE, nx=1.
- 0x7FC0 (NaN) signed -> 0x7FFFFFFF, nv=1. Unsigned -> 0xFFFFFFFF, nv=1. 0xFF80 (-inf) signed -> 0x80000000, nv=1.
- 0x4F00 (2^31):
  - signed -> 0x7FFFFFFF, nv=1;
  - unsigned -> 0x80000000, no flags;
  - 0xCF00 (-2^31) signed -> 0x80000000, no flags.
- Unsigned 0xBF00 (-0.5) with RTZ -> 0, nv=0, nx=1. Unsigned 0xBF80 (-1.0) -> 0, nv=1. Unsigned 0x8000 (-0.0) -> 0, no flags.
- Backpressure:
  - hold out_ready=0 for 5 cycles while offering 4 ops: in_ready drops after 3 ops are held;
  - out_* stay stable throughout;
  - on release, results drain in order, tags match.
  - Assert rst mid-stream: out_valid=0 immediately, and no stale results appear afterwards.
